// File: rtl/ft_pkg.sv
// ft_pkg
// Shared definitions for the lockstep fault-recovery slice: the recovery FSM
// state type, default widths and the architectural zero register value.
package ft_pkg;

  localparam int ADDR_WIDTH_DEF = 5;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int CNT_WIDTH_DEF  = 8;

  // Value that register x0 always reads as
  localparam logic [DATA_WIDTH_DEF-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HALT    = 2'd1,
    RESTORE = 2'd2,
    JUMP    = 2'd3
  } ft_rec_state_e;

endpackage

// File: rtl/ft_shadow_rf.sv
// ft_shadow_rf
// Shadow copy of the architectural register file, holding only values the
// lockstep comparator has validated.
// Ports:
//   clk   - clock
//   rst   - asynchronous active-high reset, clears every entry
//   we    - synchronous write enable
//   waddr - write address (writes to entry 0 are dropped)
//   wdata - write data
//   raddr - combinational read address
//   rdata - read data (entry 0 always reads as zero)
module ft_shadow_rf
  import ft_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Entry 0 is never written, so after reset it stays zero as well
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  // x0 is masked on the read side too, so it is zero regardless of storage
  assign rdata = (raddr == '0) ? DATA_WIDTH'(REG_ZERO) : mem[raddr];

endmodule

// File: rtl/ft_recovery_unit.sv
// ft_recovery_unit
// Recovery controller behind the lockstep write-back comparator. It mirrors
// validated register writes into a shadow file; on a comparator mismatch it
// halts both cores, replays the shadow file into both register files and
// reloads the PC of the faulting instruction.
// Ports:
//   clk_i, rst_i          - clock, asynchronous active-high reset
//   valid_instr_i         - comparator inputs belong to a retiring instruction
//   we_i, addr_i, data_i  - validated register write
//   error_i               - comparator mismatch (qualified by valid_instr_i)
//   pc_i                  - PC of the retiring instruction
//   halted_i              - both cores stalled and drained
//   halt_o                - stall request to both cores
//   recovery_o            - high in any non-IDLE state
//   rf_we_o/addr_o/data_o - restore write port into both register files
//   pc_restore_valid_o    - one-cycle PC reload pulse
//   pc_restore_o          - PC to reload
//   error_count_o         - saturating count of detected errors
module ft_recovery_unit
  import ft_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_instr_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  error_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic                  halted_i,
  output logic                  halt_o,
  output logic                  recovery_o,
  output logic                  rf_we_o,
  output logic [ADDR_WIDTH-1:0] rf_addr_o,
  output logic [DATA_WIDTH-1:0] rf_data_o,
  output logic                  pc_restore_valid_o,
  output logic [DATA_WIDTH-1:0] pc_restore_o,
  output logic [CNT_WIDTH-1:0]  error_count_o
);

  ft_rec_state_e         state;
  logic [ADDR_WIDTH-1:0] idx;
  logic [DATA_WIDTH-1:0] err_pc;
  logic [CNT_WIDTH-1:0]  err_count;
  logic [DATA_WIDTH-1:0] shadow_rdata;
  logic                  in_idle;
  logic                  take_error;
  logic                  shadow_we;

  assign in_idle    = (state == IDLE);
  assign take_error = in_idle && valid_instr_i && error_i;
  // A mismatching instruction must never reach the shadow copy
  assign shadow_we  = in_idle && valid_instr_i && !error_i && we_i && (addr_i != '0);

  ft_shadow_rf #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_shadow (
    .clk   (clk_i),
    .rst   (rst_i),
    .we    (shadow_we),
    .waddr (addr_i),
    .wdata (data_i),
    .raddr (idx),
    .rdata (shadow_rdata)
  );

  // Recovery sequencing. RESTORE walks idx from 1 up to all-ones; the wrap
  // back to 0 coincides with the move to JUMP, so x0 is never replayed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      idx       <= '0;
      err_pc    <= '0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take_error) begin
            err_pc <= pc_i;
            if (err_count != '1) begin
              err_count <= err_count + CNT_WIDTH'(1);
            end
            state <= HALT;
          end
        end
        HALT: begin
          if (halted_i) begin
            idx   <= ADDR_WIDTH'(1);
            state <= RESTORE;
          end
        end
        RESTORE: begin
          idx <= idx + ADDR_WIDTH'(1);
          if (idx == '1) begin
            state <= JUMP;
          end
        end
        JUMP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode straight from registered state so reset clears them at once
  always_comb begin
    halt_o             = !in_idle;
    recovery_o         = !in_idle;
    rf_we_o            = (state == RESTORE);
    rf_addr_o          = '0;
    rf_data_o          = '0;
    pc_restore_valid_o = (state == JUMP);
    pc_restore_o       = '0;
    error_count_o      = err_count;
    if (state == RESTORE) begin
      rf_addr_o = idx;
      rf_data_o = shadow_rdata;
    end
    if (state == JUMP) begin
      pc_restore_o = err_pc;
    end
  end

endmodule

// File: doc/ft_recovery_unit.md
# ft_recovery_unit

Recovery controller sitting directly downstream of the lockstep write-back comparator. It holds a shadow copy of every register write the comparator has validated. On a reported mismatch it halts both cores and writes the shadow contents back into both register files. It then redirects both cores to the PC of the faulting instruction, so execution re-runs from the last known-good architectural state.

## Interface
Parameters:
- ADDR_WIDTH, 5, register-file address width
- DATA_WIDTH, 32, register and PC width
- CNT_WIDTH, 8, error counter width

Ports (one clock; reset is asynchronous and active-high):
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- valid_instr_i  in  1  comparator inputs belong to a retiring instruction
- we_i  in  1  validated write enable (core A copy)
- addr_i  in  ADDR_WIDTH  validated write address
- data_i  in  DATA_WIDTH  validated write data
- error_i  in  1  comparator mismatch; meaningful only with valid_instr_i
- pc_i  in  DATA_WIDTH  PC of the retiring instruction
- halted_i  in  1  both cores stalled and drained (AND of core acks)
- halt_o  out  1  stall request to both cores
- recovery_o  out  1  high while in any non-IDLE state
- rf_we_o  out  1  restore write enable into both register files
- rf_addr_o  out  ADDR_WIDTH  restore address
- rf_data_o  out  DATA_WIDTH  restore data
- pc_restore_valid_o  out  1  one-cycle PC reload pulse
- pc_restore_o  out  DATA_WIDTH  PC to reload
- error_count_o  out  CNT_WIDTH  saturating count of detected errors

## Operation
- Shadow update happens in IDLE when valid_instr_i & !error_i & we_i & addr_i != 0. It writes shadow[addr_i] = data_i. Entry 0 is constant 0.
- Error capture happens in IDLE when valid_instr_i & error_i:
  - latch err_pc = pc_i;
  - increment error_count_o, saturating at all-ones;
  - go to HALT.
  - No shadow write occurs that cycle, even if we_i = 1; the error wins.
- States (typedef in package):
  - IDLE
    - halt_o = 0, recovery_o = 0.
    - Goes to HALT on error.
  - HALT
    - halt_o = 1.
    - Waits for halted_i = 1, then goes to RESTORE with idx = 1. There is no timeout.
  - RESTORE
    - halt_o = 1, rf_we_o = 1, rf_addr_o = idx, rf_data_o = shadow[idx].
    - idx increments each cycle.
    - After idx = 2^ADDR_WIDTH−1, goes to JUMP.
  - JUMP
    - halt_o = 1, pc_restore_valid_o = 1, pc_restore_o = err_pc.
    - Goes to IDLE.
- While not in IDLE, valid_instr_i, error_i and the write inputs are ignored: no shadow writes, no further counts.
- The idx counter is ADDR_WIDTH bits. Wrap from all-ones to 0 terminates RESTORE; x0 is never written.
- rf_* and pc_restore_* outputs are 0 whenever not in their own state.

## Timing
- All outputs are registered (state-decoded from registered state). After reset, every output is 0, the state is IDLE, the shadow is all 0 and the counter is 0.
- If rst_i is asserted mid-recovery, the block returns to IDLE immediately (asynchronously), halt_o drops to 0 and the shadow is cleared.
- Error seen at edge T: halt_o = 1 from T+1.
- halted_i first sampled high at edge H:
  - RESTORE writes occupy H+1 … H+2^ADDR_WIDTH−1 (31 cycles at default width);
  - the JUMP pulse is in the next cycle;
  - halt_o = 0 in the cycle after the pulse.
- Total halt-to-release after halted_i: 2^ADDR_WIDTH + 1 cycles.
- If halted_i drops during RESTORE, it is ignored; the cores must hold halt until halt_o falls.
- A shadow write and an error are never in the same cycle because the error wins. A shadow write in IDLE is visible to a restore starting at the next edge.

## Structure
- Package ft_pkg:
  - ft_rec_state_e {IDLE, HALT, RESTORE, JUMP};
  - default widths;
  - constant REG_ZERO = '0.
- Sub-module ft_shadow_rf:
  - 2^ADDR_WIDTH × DATA_WIDTH flops;
  - one synchronous write port;
  - one combinational read port;
  - entry 0 hardwired to 0;
  - async active-high reset clears all entries.
- The top level contains the FSM, idx counter, err_pc register and error counter.

## Test plan
- Reset then three validated writes (x1 = 0x11, x5 = 0x55, x31 = 0xFFFF_0001), then error with pc_i = 0x0000_0100 and halted_i tied high. Expected:
  - 31 rf_we_o beats with x1 = 0x11, x5 = 0x55, x31 = 0xFFFF_0001, all others 0;
  - a pc_restore pulse of 0x100;
  - error_count_o = 1.
- Same-cycle error with we_i = 1, addr_i = 3, data_i = 0xDEAD. Expected: x3 restored as its prior value 0, not 0xDEAD.
- halted_i held low for 10 cycles after error. Expected: halt_o = 1 throughout, no rf_we_o until the cycle after halted_i rises.
- Writes to addr 0 (data 0xAAAA), then error. Expected: the restore sequence never drives addr 0, and shadow[0] reads 0.
- Reset asserted on the 5th RESTORE beat. Expected: all outputs 0 asynchronously, state IDLE; a new error afterwards restores all-zero contents.
- 300 error/recovery rounds. Expected: error_count_o saturates at 255; an error arriving during RESTORE is not counted.
